// File: rtl/adder_pkg.sv
// rtl/adder_pkg.sv - shared constants for the nibble-serial adder
package adder_pkg;

  localparam int NIB_W = 4;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

endpackage

// File: rtl/fulladder.sv
// rtl/fulladder.sv - 4-bit combinational adder slice
module fulladder (
  input  logic [3:0] A,
  input  logic [3:0] B,
  input  logic       Ci,
  output logic [3:0] Z,
  output logic       Co
);

  assign {Co, Z} = {1'b0, A} + {1'b0, B} + {4'b0000, Ci};

endmodule

// File: rtl/nibble_serial_adder.sv
// rtl/nibble_serial_adder.sv - WIDTH-bit adder that reuses one 4-bit slice, LSB nibble first
module nibble_serial_adder
  import adder_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int NIB   = WIDTH / NIB_W;
  localparam int IDX_W = (NIB > 1) ? $clog2(NIB) : 1;
  localparam logic [IDX_W-1:0] LAST = IDX_W'(NIB - 1);

  logic [1:0]       state;
  logic [WIDTH-1:0] a_r;
  logic [WIDTH-1:0] b_r;
  logic             carry_r;
  logic [IDX_W-1:0] idx;
  logic [3:0]       a_nib;
  logic [3:0]       b_nib;
  logic [3:0]       z;
  logic             co;

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);

  always_comb begin
    a_nib = '0;
    b_nib = '0;
    for (int i = 0; i < NIB; i++) begin
      if (idx == IDX_W'(i)) begin
        a_nib = a_r[NIB_W*i +: NIB_W];
        b_nib = b_r[NIB_W*i +: NIB_W];
      end
    end
  end

  fulladder u_slice (
    .A  (a_nib),
    .B  (b_nib),
    .Ci (carry_r),
    .Z  (z),
    .Co (co)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      a_r     <= '0;
      b_r     <= '0;
      carry_r <= 1'b0;
      idx     <= '0;
      sum     <= '0;
      cout    <= 1'b0;
      ovf     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_r     <= a;
            b_r     <= b;
            carry_r <= cin;
            idx     <= '0;
            state   <= RUN;
          end
        end
        RUN: begin
          for (int i = 0; i < NIB; i++) begin
            if (idx == IDX_W'(i)) sum[NIB_W*i +: NIB_W] <= z;
          end
          carry_r <= co;
          // idx parks on the last nibble instead of wrapping
          if (idx == LAST) begin
            cout  <= co;
            ovf   <= a_r[WIDTH-1] ^ b_r[WIDTH-1] ^ z[3] ^ co;
            state <= DONE;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        DONE: begin
          if (out_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_nibble_serial_adder.sv
// tb/tb_nibble_serial_adder.sv - directed scoreboard bench for nibble_serial_adder
module tb_nibble_serial_adder;

  localparam int WIDTH = 16;

  typedef struct packed {
    logic [WIDTH-1:0] s;
    logic             c;
    logic             v;
  } res_t;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;

  int   vectors = 0;
  int   miscompares = 0;
  res_t sb[$];

  always #5 clk = ~clk;

  nibble_serial_adder #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .ovf       (ovf)
  );

  function automatic res_t model(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y, input logic ci);
    res_t r;
    logic [WIDTH:0] full;
    full = {1'b0, x} + {1'b0, y} + {{WIDTH{1'b0}}, ci};
    r.s = full[WIDTH-1:0];
    r.c = full[WIDTH];
    r.v = (x[WIDTH-1] == y[WIDTH-1]) && (r.s[WIDTH-1] != x[WIDTH-1]);
    return r;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pop_check(input string tag);
    res_t e;
    if (sb.size() == 0) begin
      chk({tag, "_sb_empty"}, 32'd1, 32'd0);
    end else begin
      e = sb.pop_front();
      chk({tag, "_sum"}, 32'(sum), 32'(e.s));
      chk({tag, "_cout"}, 32'(cout), 32'(e.c));
      chk({tag, "_ovf"}, 32'(ovf), 32'(e.v));
    end
  endtask

  // Handshake, wait for out_valid with a bound, check latency and result.
  task automatic start_and_wait(input string tag, input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y, input logic ci);
    int n;
    chk({tag, "_in_ready"}, 32'(in_ready), 32'd1);
    a = x; b = y; cin = ci; in_valid = 1'b1;
    sb.push_back(model(x, y, ci));
    tick();
    in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 20) begin
      tick();
      n++;
    end
    chk({tag, "_latency"}, 32'(n), 32'd4);
  endtask

  task automatic release_result(input string tag);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk({tag, "_out_valid_drop"}, 32'(out_valid), 32'd0);
    chk({tag, "_idle_ready"}, 32'(in_ready), 32'd1);
  endtask

  initial begin
    res_t held;
    int cyc;
    int last_hs;
    int got;

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; cin = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_sum", 32'(sum), 32'd0);
    chk("rst_cout", 32'(cout), 32'd0);
    chk("rst_ovf", 32'(ovf), 32'd0);

    start_and_wait("t1", 16'h0002, 16'h0001, 1'b1);
    pop_check("t1");
    release_result("t1");

    start_and_wait("t2", 16'h0FFF, 16'h0001, 1'b0);
    pop_check("t2");
    release_result("t2");

    start_and_wait("t3", 16'hFFFF, 16'hFFFF, 1'b1);
    pop_check("t3");
    release_result("t3");

    start_and_wait("t4", 16'h7FFF, 16'h0001, 1'b0);
    pop_check("t4");
    release_result("t4");

    // Stall in DONE while new operands are offered
    start_and_wait("hold", 16'hA5C3, 16'h1E2F, 1'b1);
    held = model(16'hA5C3, 16'h1E2F, 1'b1);
    pop_check("hold");
    for (int i = 0; i < 5; i++) begin
      a = 16'($urandom); b = 16'($urandom); cin = 1'($urandom);
      in_valid = ~in_valid;
      tick();
      chk("hold_sum", 32'(sum), 32'(held.s));
      chk("hold_cout", 32'(cout), 32'(held.c));
      chk("hold_ovf", 32'(ovf), 32'(held.v));
      chk("hold_in_ready", 32'(in_ready), 32'd0);
      chk("hold_out_valid", 32'(out_valid), 32'd1);
    end
    in_valid = 1'b0;
    release_result("hold");
    start_and_wait("after_hold", 16'h0F0F, 16'h00F1, 1'b0);
    pop_check("after_hold");
    release_result("after_hold");

    // Abort after two RUN cycles
    chk("abort_in_ready", 32'(in_ready), 32'd1);
    a = 16'h9999; b = 16'h8888; cin = 1'b1; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("abort_in_ready", 32'(in_ready), 32'd1);
    chk("abort_out_valid", 32'(out_valid), 32'd0);
    chk("abort_sum", 32'(sum), 32'd0);
    chk("abort_cout", 32'(cout), 32'd0);
    chk("abort_ovf", 32'(ovf), 32'd0);
    start_and_wait("post_abort", 16'h1234, 16'h4321, 1'b0);
    chk("post_abort_value", 32'(sum), 32'h5555);
    pop_check("post_abort");
    release_result("post_abort");

    // Back-to-back with both handshakes held high
    a = 16'h8000; b = 16'h8000; cin = 1'b0;
    in_valid = 1'b1; out_ready = 1'b1;
    cyc = 0; last_hs = -1; got = 0;
    while (got < 3 && cyc < 60) begin
      if (out_valid) begin
        pop_check("b2b");
        got++;
      end
      if (in_ready) begin
        sb.push_back(model(16'h8000, 16'h8000, 1'b0));
        if (last_hs >= 0) chk("b2b_spacing", 32'(cyc - last_hs), 32'd6);
        last_hs = cyc;
      end
      tick();
      cyc++;
    end
    in_valid = 1'b0;
    out_ready = 1'b0;
    chk("b2b_results", 32'(got), 32'd3);
    sb.delete();
    tick();
    chk("b2b_idle", 32'(in_ready), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/nibble_serial_adder.md
Name: nibble_serial_adder

Overview:
- Multi-cycle wide adder built around the existing 4-bit `fulladder` slice (ports A[3:0], B[3:0], Ci -> Z[3:0], Co).
- Accepts a WIDTH-bit operand pair plus carry-in over a valid/ready handshake.
- Feeds the slice one nibble per cycle, LSB nibble first, with the carry held in a register between cycles.
- Collects the slice outputs into a WIDTH-bit result and presents it downstream with valid/ready.

Parameters:
WIDTH, 16, operand/result width in bits; must be a multiple of 4 and >= 4
NIB, WIDTH/4, derived nibble count = number of slice cycles; not overridable

Ports:
clk  input  1  system clock, all state changes on rising edge
rst  input  1  synchronous, active-high reset
in_valid  input  1  operand pair valid
in_ready  output  1  block can accept operands (high only in IDLE)
a  input  WIDTH  operand A
b  input  WIDTH  operand B
cin  input  1  carry-in to nibble 0
out_valid  output  1  result valid (high only in DONE)
out_ready  input  1  downstream accepts result
sum  output  WIDTH  registered result
cout  output  1  carry out of MSB nibble
ovf  output  1  signed overflow (carry into MSB xor carry out of MSB)

Behaviour:
- Single clock domain. Reset is synchronous and active-high on clk/rst.
- Reset values: state=IDLE, in_ready=1, out_valid=0, sum=0, cout=0, ovf=0, internal a/b/carry/index registers=0.
- States:
  - IDLE:
    - in_ready=1.
    - On in_valid&&in_ready: latch a, b into operand registers; carry_r<=cin; idx<=0; go RUN.
  - RUN:
    - in_ready=0, out_valid=0.
    - Each cycle, the slice receives A=a_r[4*idx+:4], B=b_r[4*idx+:4], Ci=carry_r.
    - On the edge: sum[4*idx+:4]<=Z; carry_r<=Co; idx<=idx+1.
    - When idx==NIB-1 on that edge: cout<=Co; ovf<=(a_r[W-1]^b_r[W-1]^Z[3])^Co; go DONE.
  - DONE:
    - out_valid=1. sum, cout and ovf are held stable.
    - On out_ready: go IDLE. out_valid drops on the next edge.
- Latency: the handshake edge is T. Exactly NIB RUN cycles follow, so out_valid is high after edge T+NIB. WIDTH=4 gives one RUN cycle.
- Throughput: one transaction per NIB+2 cycles minimum. No bypass from DONE directly to IDLE-accept.
- in_valid while not in IDLE is ignored; operands are neither sampled nor queued.
- out_ready outside DONE has no effect.
- sum contents during RUN are partial and undefined to the consumer. Only values qualified by out_valid are meaningful.
- sum keeps its last value in IDLE until overwritten nibble-by-nibble by the next RUN.
- Arithmetic: result modulo 2^WIDTH. cout is the true carry of a+b+cin.
- Reset mid-RUN or mid-DONE: abort on that edge. All outputs return to their reset values and the transaction is discarded.
- Reset has priority over all handshakes in the same cycle.
- idx width is clog2(NIB), minimum 1 bit. idx never wraps past NIB-1.

Decomposition:
- Shared package/include adder_pkg holds: NIB_W=4, state encodings IDLE=2'd0, RUN=2'd1, DONE=2'd2.
- One sub-module: the existing `fulladder` 4-bit slice, instantiated once, inputs driven combinationally from the nibble mux.
- Control FSM and the sum/carry registers live in nibble_serial_adder.

Test Plan:
- WIDTH=16: a=0x0002, b=0x0001, cin=1 -> out_valid exactly 4 cycles after handshake; sum=0x0004, cout=0, ovf=0.
- a=0x0FFF, b=0x0001, cin=0 -> sum=0x1000, cout=0 (carry ripples through nibbles 0-2).
- a=0xFFFF, b=0xFFFF, cin=1 -> sum=0xFFFF, cout=1, ovf=0; a=0x7FFF, b=0x0001, cin=0 -> sum=0x8000, cout=0, ovf=1.
- Hold out_ready=0 for 5 cycles in DONE while toggling in_valid with new operands -> sum/cout/ovf stable, in_ready=0, new operands ignored. After out_ready=1: IDLE next cycle, then next transaction correct.
- Assert rst for one cycle after 2 RUN cycles -> next cycle in_ready=1, out_valid=0, sum=0, cout=0. A following 0x1234+0x4321, cin=0 yields 0x5555.
- Back-to-back: out_ready tied high, in_valid tied high with a=0x8000, b=0x8000 -> each result sum=0x0000, cout=1, ovf=1. Handshakes spaced 6 cycles apart.
